// File: rtl/ob_pkg.sv
// Shared types for the order-book host: BCD price, command/response formats,
// host FSM states and the in-flight table entry.
package bcd_pkg;
  typedef logic [15:0] price_t;  // four packed BCD digits
endpackage

package ob_pkg;
  typedef logic [3:0] uid_t;
  typedef logic [7:0] quantity_t;
  typedef logic [1:0] status_t;

  typedef enum logic [1:0] {
    Op_Nop    = 2'd0,
    Op_Buy    = 2'd1,
    Op_Sell   = 2'd2,
    Op_Cancel = 2'd3
  } opcode_t;

  typedef struct packed {
    quantity_t       quantity;
    bcd_pkg::price_t price;
  } oprand_buy_t;

  typedef struct packed {
    quantity_t       quantity;
    bcd_pkg::price_t price;
  } oprand_sell_t;

  localparam int OPRAND_W = $bits(oprand_buy_t);
  typedef logic [OPRAND_W-1:0] oprand_t;

  typedef struct packed {
    uid_t    uid;
    opcode_t opcode;
    oprand_t oprand;
  } cmd_t;

  typedef struct packed {
    uid_t    uid;
    status_t status;
  } rsp_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } host_state_t;

  typedef struct packed {
    logic valid;
    uid_t uid;
  } tbl_entry_t;

  // Only priced orders carry an operand; everything else sends zero.
  function automatic oprand_t pack_oprand(opcode_t op, quantity_t qty, bcd_pkg::price_t price);
    oprand_buy_t  b;
    oprand_sell_t s;
    oprand_t      o;
    b = '{quantity: qty, price: price};
    s = '{quantity: qty, price: price};
    case (op)
      Op_Buy:  o = b;
      Op_Sell: o = s;
      default: o = '0;
    endcase
    return o;
  endfunction
endpackage

// File: rtl/ob_host_tbl.sv
// In-flight command table: allocate lowest free slot, lookup/free by uid.
// Timestamps and the cycle counter exist only with OB_HOST_LATENCY_EN defined.
module ob_host_tbl
  import ob_pkg::*;
#(
  parameter int N     = 4,
  parameter int LAT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  uid_t             alloc_uid,
  input  uid_t             lookup_uid,
  input  logic             free,
  input  uid_t             busy_uid,
  output logic             full,
  output logic             uid_busy,
  output logic             hit,
  output logic [LAT_W-1:0] hit_latency
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  tbl_entry_t       entries [N];
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] hit_idx;

  // Scan downwards so the lowest free slot wins.
  always_comb begin
    free_idx = '0;
    hit_idx  = '0;
    full     = 1'b1;
    hit      = 1'b0;
    uid_busy = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      free_idx = entries[i].valid ? free_idx : IDX_W'(i);
      full     = full & entries[i].valid;
    end
    for (int i = 0; i < N; i++) begin
      hit_idx  = (entries[i].valid && entries[i].uid == lookup_uid) ? IDX_W'(i) : hit_idx;
      hit      = hit | (entries[i].valid && entries[i].uid == lookup_uid);
      uid_busy = uid_busy | (entries[i].valid && entries[i].uid == busy_uid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (free && hit) begin
        entries[hit_idx].valid <= 1'b0;
      end
      if (alloc && !full) begin
        entries[free_idx] <= '{valid: 1'b1, uid: alloc_uid};
      end
    end
  end

`ifdef OB_HOST_LATENCY_EN
  logic [LAT_W-1:0] now_r;
  logic [LAT_W-1:0] ts_r [N];
  logic [N-1:0]     aged_r;

  // An entry is marked aged on the edge its elapsed count would wrap past all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      now_r  <= '0;
      aged_r <= '0;
    end else begin
      now_r <= now_r + LAT_W'(1);
      for (int i = 0; i < N; i++) begin
        if (entries[i].valid && ((now_r - ts_r[i]) == {LAT_W{1'b1}})) begin
          aged_r[i] <= 1'b1;
        end
      end
      if (alloc && !full) begin
        ts_r[free_idx]   <= now_r;
        aged_r[free_idx] <= 1'b0;
      end
    end
  end

  assign hit_latency = aged_r[hit_idx] ? {LAT_W{1'b1}} : (now_r - ts_r[hit_idx]);
`else
  assign hit_latency = '0;
`endif
endmodule

// File: rtl/ob_host.sv
// Order-book host: issues client commands with rolling uids, matches responses,
// reports completions with latency (OB_HOST_LATENCY_EN) and supports drain.
module ob_host
  import ob_pkg::*;
#(
  parameter int N_OUTSTANDING = 4,
  parameter int LAT_W         = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_vld,
  input  opcode_t                              req_opcode,
  input  quantity_t                            req_quantity,
  input  bcd_pkg::price_t                      req_price,
  output logic                                 req_accept,
  output logic                                 cmd_vld_r,
  output cmd_t                                 cmd_r,
  input  logic                                 cmd_full_r,
  input  logic                                 rsp_vld,
  input  rsp_t                                 rsp,
  output logic                                 rsp_accept,
  output logic                                 cpl_vld_r,
  output uid_t                                 cpl_uid_r,
  output status_t                              cpl_status_r,
  output logic [LAT_W-1:0]                     cpl_latency_r,
  input  logic                                 cpl_accept,
  input  logic                                 drain,
  output logic                                 drain_done_r,
  output logic                                 err_uid_r,
  output logic [$clog2(N_OUTSTANDING+1)-1:0]   outstanding_r
);
  localparam int CNT_W = $clog2(N_OUTSTANDING + 1);

  host_state_t      state;
  uid_t             next_uid;
  logic             tbl_full;
  logic             uid_busy;
  logic             hit;
  logic [LAT_W-1:0] hit_latency;
  logic             acc;
  logic             rsp_take;
  logic             retire;

  assign req_accept = (state == ST_RUN) && !cmd_full_r && (outstanding_r < CNT_W'(N_OUTSTANDING))
                      && !uid_busy && !tbl_full;
  assign rsp_accept = !cpl_vld_r || cpl_accept;
  assign acc        = req_vld && req_accept;
  assign rsp_take   = rsp_vld && rsp_accept;
  assign retire     = rsp_take && hit;

  ob_host_tbl #(.N(N_OUTSTANDING), .LAT_W(LAT_W)) u_tbl (
    .clk         (clk),
    .rst         (rst),
    .alloc       (acc),
    .alloc_uid   (next_uid),
    .lookup_uid  (rsp.uid),
    .free        (retire),
    .busy_uid    (next_uid),
    .full        (tbl_full),
    .uid_busy    (uid_busy),
    .hit         (hit),
    .hit_latency (hit_latency)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_vld_r <= 1'b0;
      cmd_r     <= '0;
      next_uid  <= '0;
    end else begin
      cmd_vld_r <= acc;
      if (acc) begin
        cmd_r    <= '{uid: next_uid, opcode: req_opcode,
                      oprand: pack_oprand(req_opcode, req_quantity, req_price)};
        next_uid <= next_uid + uid_t'(1);
      end
    end
  end

  // A new completion may replace the one being accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpl_vld_r     <= 1'b0;
      cpl_uid_r     <= '0;
      cpl_status_r  <= '0;
      cpl_latency_r <= '0;
      err_uid_r     <= 1'b0;
    end else begin
      if (retire) begin
        cpl_vld_r     <= 1'b1;
        cpl_uid_r     <= rsp.uid;
        cpl_status_r  <= rsp.status;
        cpl_latency_r <= hit_latency;
      end else if (cpl_accept) begin
        cpl_vld_r <= 1'b0;
      end
      if (rsp_take && !hit) begin
        err_uid_r <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_r <= '0;
    end else begin
      case ({acc, retire})
        2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      drain_done_r <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          drain_done_r <= 1'b0;
          if (drain) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (outstanding_r == '0 && !cpl_vld_r) begin
            state        <= ST_DONE;
            drain_done_r <= 1'b1;
          end
        end
        ST_DONE: begin
          drain_done_r <= 1'b0;
          state        <= ST_RUN;
        end
        default: begin
          drain_done_r <= 1'b0;
          state        <= ST_RUN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ob_host.sv
// Scoreboard bench for ob_host: a behavioural model predicts handshakes,
// commands and completions; a negedge monitor compares against the DUT.
module tb_ob_host;
  import ob_pkg::*;

  localparam int N     = 4;
  localparam int LAT_W = 16;
  localparam int CNT_W = $clog2(N + 1);
`ifdef OB_HOST_LATENCY_EN
  localparam int LAT_ON = 1;
`else
  localparam int LAT_ON = 0;
`endif

  logic             clk;
  logic             rst;
  logic             req_vld;
  opcode_t          req_opcode;
  quantity_t        req_quantity;
  bcd_pkg::price_t  req_price;
  logic             req_accept;
  logic             cmd_vld_r;
  cmd_t             cmd_r;
  logic             cmd_full_r;
  logic             rsp_vld;
  rsp_t             rsp;
  logic             rsp_accept;
  logic             cpl_vld_r;
  uid_t             cpl_uid_r;
  status_t          cpl_status_r;
  logic [LAT_W-1:0] cpl_latency_r;
  logic             cpl_accept;
  logic             drain;
  logic             drain_done_r;
  logic             err_uid_r;
  logic [CNT_W-1:0] outstanding_r;

  ob_host #(.N_OUTSTANDING(N), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_opcode(req_opcode),
    .req_quantity(req_quantity), .req_price(req_price), .req_accept(req_accept),
    .cmd_vld_r(cmd_vld_r), .cmd_r(cmd_r), .cmd_full_r(cmd_full_r),
    .rsp_vld(rsp_vld), .rsp(rsp), .rsp_accept(rsp_accept),
    .cpl_vld_r(cpl_vld_r), .cpl_uid_r(cpl_uid_r), .cpl_status_r(cpl_status_r),
    .cpl_latency_r(cpl_latency_r), .cpl_accept(cpl_accept), .drain(drain),
    .drain_done_r(drain_done_r), .err_uid_r(err_uid_r), .outstanding_r(outstanding_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model state (spec-level view: a set of busy uids, counts, phase)
  typedef struct { int uid; int status; int lat; } cpl_exp_t;
  bit       chk_en = 1'b0;
  int       m_state;        // 0 running, 1 draining, 2 drain finished
  int       m_cnt;
  bit       m_busy [16];
  int       m_issue [16];
  int       m_next;
  bit       m_cpl_vld, m_cmd_vld, m_err, m_rsp_taken;
  int       cyc;
  cmd_t     exp_cmd_q [$];
  cpl_exp_t exp_cpl_q [$];

  function automatic bit pred_req_accept();
    return (m_state == 0) && !cmd_full_r && (m_cnt < N) && !m_busy[m_next];
  endfunction

  always @(posedge clk) begin
    bit       acc, rsp_acc, ret;
    int       nstate;
    cmd_t     e;
    cpl_exp_t c;
    if (rst) begin
      chk_en = 1'b1;
      m_state = 0; m_cnt = 0; m_next = 0; cyc = 0;
      m_cpl_vld = 0; m_cmd_vld = 0; m_err = 0; m_rsp_taken = 0;
      for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
      exp_cmd_q.delete();
      exp_cpl_q.delete();
    end else begin
      acc = req_vld && pred_req_accept();
      rsp_acc = !m_cpl_vld || cpl_accept;
      m_rsp_taken = rsp_vld && rsp_acc;
      ret = m_rsp_taken && m_busy[rsp.uid];
      nstate = m_state;
      if (m_state == 0 && drain) nstate = 1;
      if (m_state == 1 && m_cnt == 0 && !m_cpl_vld) nstate = 2;
      if (m_state == 2) nstate = 0;
      if (m_cpl_vld && cpl_accept && exp_cpl_q.size() > 0) void'(exp_cpl_q.pop_front());
      if (ret) begin
        m_busy[rsp.uid] = 1'b0;
        c.uid = int'(rsp.uid);
        c.status = int'(rsp.status);
        c.lat = LAT_ON ? ((cyc - m_issue[rsp.uid]) % 65536) : 0;
        exp_cpl_q.push_back(c);
      end
      if (m_rsp_taken && !ret) m_err = 1'b1;
      m_cpl_vld = ret ? 1'b1 : (cpl_accept ? 1'b0 : m_cpl_vld);
      if (acc) begin
        e.uid = uid_t'(m_next);
        e.opcode = req_opcode;
        e.oprand = (req_opcode == Op_Buy || req_opcode == Op_Sell) ? {req_quantity, req_price} : '0;
        exp_cmd_q.push_back(e);
        m_busy[m_next] = 1'b1;
        m_issue[m_next] = cyc;
        m_next = (m_next + 1) % 16;
      end
      m_cnt = m_cnt + int'(acc) - int'(ret);
      m_cmd_vld = acc;
      m_state = nstate;
      cyc++;
    end
  end

  // Monitor: compare every output against the model away from the clock edge.
  always @(negedge clk) begin
    cmd_t     e;
    cpl_exp_t c;
    if (chk_en) begin
      check("req_accept", req_accept, pred_req_accept());
      check("rsp_accept", rsp_accept, !m_cpl_vld || cpl_accept);
      check("outstanding", outstanding_r, m_cnt);
      check("err_uid", err_uid_r, m_err);
      check("drain_done", drain_done_r, m_state == 2);
      check("cmd_vld", cmd_vld_r, m_cmd_vld);
      check("cpl_vld", cpl_vld_r, m_cpl_vld);
      if (cmd_vld_r) begin
        check("cmd_expected", exp_cmd_q.size() != 0, 1);
        if (exp_cmd_q.size() != 0) begin
          e = exp_cmd_q.pop_front();
          check("cmd_uid", cmd_r.uid, e.uid);
          check("cmd_opcode", cmd_r.opcode, e.opcode);
          check("cmd_oprand", cmd_r.oprand, e.oprand);
        end
      end
      if (cpl_vld_r) begin
        check("cpl_expected", exp_cpl_q.size() != 0, 1);
        if (exp_cpl_q.size() != 0) begin
          c = exp_cpl_q[0];
          check("cpl_uid", cpl_uid_r, c.uid);
          check("cpl_status", cpl_status_r, c.status);
          check("cpl_latency", cpl_latency_r, c.lat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_vld = 0; req_opcode = Op_Nop; req_quantity = '0; req_price = '0;
    cmd_full_r = 0; rsp_vld = 0; rsp = '0; cpl_accept = 1; drain = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic issue(input opcode_t op, input int q, input int p);
    req_vld = 1; req_opcode = op; req_quantity = quantity_t'(q); req_price = bcd_pkg::price_t'(p);
    for (int k = 0; k < 30; k++) begin
      if (pred_req_accept()) begin
        tick();
        req_vld = 0;
        return;
      end
      tick();
    end
    req_vld = 0;
    checks++; errors++;
    $display("FAIL issue_timeout op=%0d", op);
  endtask

  task automatic respond(input int u, input int s);
    rsp_vld = 1; rsp = '{uid: uid_t'(u), status: status_t'(s)};
    for (int k = 0; k < 50; k++) begin
      tick();
      if (m_rsp_taken) begin
        rsp_vld = 0;
        return;
      end
    end
    rsp_vld = 0;
    checks++; errors++;
    $display("FAIL respond_timeout uid=%0d", u);
  endtask

  initial begin
    int acc_cnt, pulses, off, u;
    bit found;
    rst = 1;
    idle_inputs();

    // Single buy, order book answers five cycles after the command
    do_reset();
    req_vld = 1; req_opcode = Op_Buy; req_quantity = 8'd10; req_price = 16'h0100;
    tick();
    req_vld = 0;
    @(negedge clk);
    check("t043_cmd_vld", cmd_vld_r, 1);
    check("t043_cmd_uid", cmd_r.uid, 0);
    check("t043_oprand", cmd_r.oprand, 24'h0A0100);
    repeat (5) tick();
    rsp_vld = 1; rsp = '{uid: 4'd0, status: 2'd1};
    tick();
    rsp_vld = 0;
    @(negedge clk);
    check("t043_cpl_vld", cpl_vld_r, 1);
    check("t043_cpl_uid", cpl_uid_r, 0);
    check("t043_latency", cpl_latency_r, LAT_ON ? 6 : 0);
    tick();

    // Five back-to-back requests against a four-deep table
    do_reset();
    acc_cnt = 0;
    req_vld = 1; req_opcode = Op_Sell; req_quantity = 8'd3; req_price = 16'h0042;
    repeat (5) begin
      @(negedge clk);
      if (req_accept) acc_cnt++;
      tick();
    end
    req_vld = 0;
    @(negedge clk);
    check("t044_accepts", acc_cnt, 4);
    check("t044_outstanding", outstanding_r, 4);
    check("t044_req_accept", req_accept, 0);
    tick();
    for (int i = 0; i < 4; i++) respond(i, i);
    tick();

    // Back-pressure from the order book for three cycles
    do_reset();
    cmd_full_r = 1; req_vld = 1; req_opcode = Op_Buy; req_quantity = 8'd7; req_price = 16'h0999;
    repeat (3) begin
      @(negedge clk);
      check("t045_no_cmd", cmd_vld_r, 0);
      tick();
    end
    cmd_full_r = 0;
    @(negedge clk);
    check("t045_no_cmd_yet", cmd_vld_r, 0);
    tick();
    req_vld = 0;
    @(negedge clk);
    check("t045_cmd_issued", cmd_vld_r, 1);
    tick();
    respond(0, 0);

    // Response for a uid that is not in flight
    do_reset();
    issue(Op_Buy, 1, 1);
    respond(7, 3);
    @(negedge clk);
    check("t046_err", err_uid_r, 1);
    check("t046_no_cpl", cpl_vld_r, 0);
    check("t046_still_out", outstanding_r, 1);
    tick();
    respond(0, 1);
    tick();

    // Completion held while the client stalls
    do_reset();
    cpl_accept = 0;
    issue(Op_Buy, 5, 5);
    issue(Op_Cancel, 6, 6);
    rsp_vld = 1; rsp = '{uid: 4'd0, status: 2'd1};
    tick();
    rsp = '{uid: 4'd1, status: 2'd2};
    repeat (4) begin
      @(negedge clk);
      check("t047_cpl_held", cpl_vld_r, 1);
      check("t047_uid_stable", cpl_uid_r, 0);
      check("t047_status_stable", cpl_status_r, 1);
      check("t047_rsp_blocked", rsp_accept, 0);
      tick();
    end
    cpl_accept = 1;
    @(negedge clk);
    check("t047_rsp_open", rsp_accept, 1);
    tick();
    rsp_vld = 0;
    @(negedge clk);
    check("t047_second_uid", cpl_uid_r, 1);
    check("t047_second_status", cpl_status_r, 2);
    tick();

    // Drain with two in flight retiring at +4 and +9
    do_reset();
    issue(Op_Buy, 2, 2);
    issue(Op_Sell, 3, 3);
    drain = 1;
    tick();
    drain = 0; req_vld = 1; req_opcode = Op_Buy;
    acc_cnt = 0; pulses = 0;
    for (int i = 0; i < 18; i++) begin
      rsp_vld = (i == 4 || i == 9);
      rsp = '{uid: (i == 4) ? 4'd0 : 4'd1, status: 2'd3};
      @(negedge clk);
      if (pulses == 0 && req_accept) acc_cnt++;
      if (drain_done_r) pulses++;
      tick();
      if (pulses > 0) req_vld = 0;
    end
    rsp_vld = 0; req_vld = 0;
    check("t048_no_accept", acc_cnt, 0);
    check("t048_one_pulse", pulses, 1);
    @(negedge clk);
    check("t048_empty", outstanding_r, 0);
    tick();

    // Randomised traffic with a mid-run reset
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = (c >= 1500 && c < 1502);
      req_vld = 1'($urandom_range(0, 1));
      req_opcode = opcode_t'($urandom_range(0, 3));
      req_quantity = quantity_t'($urandom);
      req_price = bcd_pkg::price_t'($urandom);
      cmd_full_r = ($urandom_range(0, 4) == 0);
      cpl_accept = ($urandom_range(0, 9) < 7);
      drain = ($urandom_range(0, 199) == 0);
      if (!rsp_vld || m_rsp_taken) begin
        rsp_vld = 0;
        if ($urandom_range(0, 9) < 4) begin
          if ($urandom_range(0, 19) == 0) begin
            rsp_vld = 1; rsp = '{uid: uid_t'($urandom), status: status_t'($urandom)};
          end else begin
            off = $urandom_range(0, 15); found = 0;
            for (int k = 0; k < 16; k++) begin
              u = (off + k) % 16;
              if (!found && m_busy[u]) begin
                found = 1; rsp_vld = 1; rsp = '{uid: uid_t'(u), status: status_t'($urandom)};
              end
            end
          end
        end
      end
      tick();
    end
    rst = 0; req_vld = 0; drain = 0; cmd_full_r = 0; cpl_accept = 1;
    for (int c = 0; c < 300; c++) begin
      if (m_cnt == 0 && !m_cpl_vld && !rsp_vld) break;
      if (!rsp_vld || m_rsp_taken) begin
        rsp_vld = 0;
        for (int k = 0; k < 16; k++) begin
          if (!rsp_vld && m_busy[k]) begin
            rsp_vld = 1; rsp = '{uid: uid_t'(k), status: 2'd0};
          end
        end
      end
      tick();
    end
    rsp_vld = 0;
    tick();
    @(negedge clk);
    check("end_outstanding", outstanding_r, 0);
    check("end_cmd_q_empty", exp_cmd_q.size(), 0);
    check("end_cpl_q_empty", exp_cpl_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ob_host.md
OB_HOST -- requirements
Module: ob_host

Interface
REQ-001 SHALL have parameter N_OUTSTANDING, default 4, giving the maximum number of in-flight commands (range 1..16).
REQ-002 SHALL have parameter LAT_W, default 16, giving the width of the latency counter.
REQ-003 clk  input  1  clock; one clock, every flop on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req_vld  input  1  client command request valid.
REQ-006 req_opcode  input  ob_pkg::opcode_t  request opcode.
REQ-007 req_quantity  input  ob_pkg::quantity_t  request quantity (Op_Buy/Op_Sell only).
REQ-008 req_price  input  bcd_pkg::price_t  request price (Op_Buy/Op_Sell only).
REQ-009 req_accept  output  1  request taken this cycle.
REQ-010 cmd_vld_r  output  1  registered command valid to the order book.
REQ-011 cmd_r  output  ob_pkg::cmd_t  registered command (uid, opcode, oprand).
REQ-012 cmd_full_r  input  1  order-book command queue full.
REQ-013 rsp_vld  input  1  order-book response valid.
REQ-014 rsp  input  ob_pkg::rsp_t  order-book response (uid, status).
REQ-015 rsp_accept  output  1  response consumed this cycle.
REQ-016 cpl_vld_r  output  1  completion valid to the client.
REQ-017 cpl_uid_r  output  ob_pkg::uid_t  uid of the completed command.
REQ-018 cpl_status_r  output  ob_pkg::status_t  status from the order book.
REQ-019 cpl_latency_r  output  LAT_W  cycles from issue to response.
REQ-020 cpl_accept  input  1  client takes the completion.
REQ-021 drain  input  1  request a drain of all in-flight commands.
REQ-022 drain_done_r  output  1  one-cycle pulse when the drain completes.
REQ-023 err_uid_r  output  1  sticky flag: a response arrived with a uid that is not outstanding.
REQ-024 outstanding_r  output  $clog2(N_OUTSTANDING+1)  count of in-flight commands.

Function
REQ-025 req_accept SHALL be (state==RUN) && !cmd_full_r && (outstanding_r<N_OUTSTANDING) && !uid_busy, where uid_busy is true when next_uid is already held in the table.
REQ-026 On req_accept, cmd_vld_r SHALL be 1 on the next cycle only, with cmd_r.uid=next_uid, cmd_r.opcode=req_opcode, and cmd_r.oprand packed as ob_pkg::oprand_buy_t or ob_pkg::oprand_sell_t; for all other opcodes the oprand SHALL be zero.
REQ-027 next_uid SHALL start at 0, increment by 1 on each accept, and wrap modulo the width of ob_pkg::uid_t.
REQ-028 On each accept, the block SHALL write the lowest free table slot with {valid, uid, issue timestamp}; the timestamp is a free-running LAT_W-bit cycle counter.
REQ-029 rsp_accept SHALL be !cpl_vld_r || cpl_accept.
REQ-030 When rsp_vld && rsp_accept and rsp.uid hits a table slot, that slot SHALL be freed and cpl_* SHALL be loaded on the next cycle.
REQ-031 cpl_latency_r SHALL be (now - issue) modulo 2^LAT_W, saturated at 2^LAT_W-1 if the entry has aged past that value.
REQ-032 When rsp_vld && rsp_accept and rsp.uid misses the table, the block SHALL set err_uid_r, consume the response, and produce no completion.
REQ-033 cpl_vld_r SHALL be held, with cpl_* stable, until cpl_accept is asserted.
REQ-034 When an accept and a retire occur in the same cycle, both SHALL take effect and outstanding_r SHALL be unchanged.
REQ-035 The FSM SHALL have states RUN, DRAIN and DONE: RUN goes to DRAIN when drain=1; DRAIN goes to DONE when outstanding_r==0 and cpl_vld_r==0; DONE pulses drain_done_r and returns to RUN.
REQ-036 Responses SHALL continue to be accepted in the DRAIN state.

Reset
REQ-037 On rst, the block SHALL go to state RUN and SHALL clear cmd_vld_r, cmd_r, cpl_vld_r, cpl_uid_r, cpl_status_r, cpl_latency_r, drain_done_r, err_uid_r, outstanding_r, next_uid, the timestamp counter and all table valid bits.
REQ-038 A reset asserted mid-operation SHALL discard in-flight entries without generating completions.

Configuration
REQ-039 With OB_HOST_LATENCY_EN defined, the block SHALL include the timestamp counter and the per-entry timestamps, and cpl_latency_r SHALL behave as in REQ-031.
REQ-040 Without OB_HOST_LATENCY_EN, the timestamp storage SHALL be absent and cpl_latency_r SHALL be constant 0.

Structure
REQ-041 The host state enumeration and the table entry struct SHALL live in ob_pkg.
REQ-042 The table SHALL be the sub-module ob_host_tbl, providing allocate, lookup and free, plus the full and uid_busy outputs.

Verification
REQ-043 Single Op_Buy (quantity 10, price 100) with the order book responding after 5 cycles -> cmd_r.uid=0 with oprand {10,100}, then cpl_uid_r=0 and cpl_latency_r=6.
REQ-044 Five back-to-back requests with N_OUTSTANDING=4 and no responses -> four accepts (uids 0..3), then req_accept=0 and outstanding_r=4.
REQ-045 cmd_full_r=1 for 3 cycles with req_vld held -> no cmd_vld_r during those cycles; the command issues on the cycle after full drops.
REQ-046 Response with uid 7 when only uid 0 is outstanding -> err_uid_r=1, no cpl_vld_r, and uid 0 is still outstanding.
REQ-047 cpl_accept held 0 with two responses pending -> rsp_accept=0 after the first completion, and cpl_* stays stable until accepted.
REQ-048 drain asserted with 2 outstanding that retire at cycles +4 and +9 -> req_accept=0 throughout, and drain_done_r pulses once after the second completion is accepted.
